// File: rtl/ft_bridge_pkg.sv
// Shared types and helpers for the FT245-style synchronous FIFO bridge.
// Used by ft_bridge (optional stats outputs under FT_BRIDGE_STATS_EN) and ft_bridge_rr_arb.
package ft_bridge_pkg;

    typedef logic [2:0] ft_state_t;

    localparam ft_state_t ST_IDLE     = 3'd0;
    localparam ft_state_t ST_TX_BURST = 3'd1;
    localparam ft_state_t ST_TX_END   = 3'd2;
    localparam ft_state_t ST_RX_OE    = 3'd3;
    localparam ft_state_t ST_RX_BURST = 3'd4;
    localparam ft_state_t ST_RX_END   = 3'd5;

    // Each turnaround/end state is a single cycle; the FSM encodes this directly.
    localparam int RX_OE_CYCLES  = 1;
    localparam int TX_END_CYCLES = 1;
    localparam int RX_END_CYCLES = 1;

    typedef enum logic {
        DIR_TX = 1'b0,
        DIR_RX = 1'b1
    } ft_dir_e;

    // Widest byte-enable bus supported (32-bit FT bus); narrower buses pad with ones.
    localparam int BE_MAX_W = 4;

    function automatic logic be_all_ones(input logic [BE_MAX_W-1:0] be);
        return &be;
    endfunction

endpackage

// File: rtl/ft_bridge_rr_arb.sv
// Two-way round-robin arbiter: on a tie the direction not served last wins.
module ft_bridge_rr_arb
    import ft_bridge_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic req_tx,
    input  logic req_rx,
    output logic grant_tx,
    output logic grant_rx
);

    ft_dir_e last_reg;

    assign grant_tx = enable && req_tx && (!req_rx || (last_reg == DIR_RX));
    assign grant_rx = enable && req_rx && (!req_tx || (last_reg == DIR_TX));

    always_ff @(posedge clk) begin
        if (reset) begin
            last_reg <= DIR_RX;
        end else if (grant_tx) begin
            last_reg <= DIR_TX;
        end else if (grant_rx) begin
            last_reg <= DIR_RX;
        end
    end

endmodule

// File: rtl/ft_bridge.sv
// Bridge between an FT-style synchronous FIFO bus and a TX/RX pair of IQ FIFOs.
// Define FT_BRIDGE_STATS_EN to add the tx_words / rx_words statistics outputs.
module ft_bridge
    import ft_bridge_pkg::*;
#(
    parameter int FT_DATA_WIDTH = 32,
    parameter int IQ_PAIR_WIDTH = 24,
    parameter int BURST_WORDS   = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       txe_n,
    input  logic                       rxf_n,
    output logic                       wr_n,
    output logic                       rd_n,
    output logic                       oe_n,
    input  logic [FT_DATA_WIDTH-1:0]   ft_data_i,
    output logic [FT_DATA_WIDTH-1:0]   ft_data_o,
    output logic                       ft_data_oe,
    input  logic [FT_DATA_WIDTH/8-1:0] ft_be_i,
    output logic [FT_DATA_WIDTH/8-1:0] ft_be_o,
    input  logic [IQ_PAIR_WIDTH-1:0]   wdata,
    input  logic                       wr_empty,
    input  logic                       wr_enough,
    output logic                       wr_req,
    output logic [IQ_PAIR_WIDTH-1:0]   rdata,
    output logic                       rd_req,
    input  logic                       rd_full,
    input  logic                       rd_enough,
    output logic                       be_drop
`ifdef FT_BRIDGE_STATS_EN
    ,
    output logic [31:0]                tx_words,
    output logic [31:0]                rx_words
`endif
);

    localparam int BE_W = FT_DATA_WIDTH / 8;
    localparam int CW   = $clog2(BURST_WORDS + 1);
    localparam logic [CW-1:0] BW_MAX  = CW'(BURST_WORDS);
    localparam logic [CW-1:0] BW_LAST = CW'(BURST_WORDS - 1);

    ft_state_t         state_reg;
    ft_state_t         state_next;
    logic [CW-1:0]     count_reg;
    logic              grant_tx;
    logic              grant_rx;
    logic              tx_beat;
    logic              rx_beat;
    logic              be_ok;
    logic              enter_burst;
    logic [BE_MAX_W-1:0] be_pad;
    logic              unused_data;

    ft_bridge_rr_arb u_arb (
        .clk      (clk),
        .reset    (reset),
        .enable   (state_reg == ST_IDLE),
        .req_tx   (!txe_n && wr_enough),
        .req_rx   (!rxf_n && rd_enough),
        .grant_tx (grant_tx),
        .grant_rx (grant_rx)
    );

    // A 16-bit bus has only two byte enables; missing lanes count as enabled.
    genvar gi;
    generate
        for (gi = 0; gi < BE_MAX_W; gi++) begin : g_be
            if (gi < BE_W) begin : g_in
                assign be_pad[gi] = ft_be_i[gi];
            end else begin : g_pad
                assign be_pad[gi] = 1'b1;
            end
        end
    endgenerate

    assign be_ok   = be_all_ones(be_pad);
    assign tx_beat = (state_reg == ST_TX_BURST) && !txe_n && !wr_empty && (count_reg < BW_MAX);
    assign rx_beat = (state_reg == ST_RX_BURST) && !rxf_n && !rd_full && (count_reg < BW_MAX);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (grant_tx) begin
                    state_next = ST_TX_BURST;
                end else if (grant_rx) begin
                    state_next = ST_RX_OE;
                end
            end
            ST_TX_BURST: begin
                if (txe_n || wr_empty || (tx_beat && count_reg == BW_LAST)) begin
                    state_next = ST_TX_END;
                end
            end
            ST_TX_END:   state_next = ST_IDLE;
            ST_RX_OE:    state_next = ST_RX_BURST;
            ST_RX_BURST: begin
                if (rxf_n || rd_full || (rx_beat && count_reg == BW_LAST)) begin
                    state_next = ST_RX_END;
                end
            end
            ST_RX_END:   state_next = ST_IDLE;
            default:     state_next = ST_IDLE;
        endcase
    end

    assign enter_burst = ((state_reg == ST_IDLE) && grant_tx) || (state_reg == ST_RX_OE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            count_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (enter_burst) begin
                count_reg <= '0;
            end else if (tx_beat || rx_beat) begin
                count_reg <= count_reg + 1'b1;
            end
        end
    end

    // Data is only driven while the pads are owned, so idle/reset shows zero.
    assign ft_data_oe = (state_reg == ST_TX_BURST) || (state_reg == ST_TX_END);
    assign ft_data_o  = ft_data_oe ? FT_DATA_WIDTH'(wdata) : '0;
    assign ft_be_o    = '1;
    assign wr_n       = !tx_beat;
    assign wr_req     = tx_beat;

    assign oe_n    = !((state_reg == ST_RX_OE) || (state_reg == ST_RX_BURST));
    assign rd_n    = !rx_beat;
    assign rdata   = ft_data_i[IQ_PAIR_WIDTH-1:0];
    assign rd_req  = rx_beat && be_ok;
    assign be_drop = rx_beat && !be_ok;

    assign unused_data = ^ft_data_i;

`ifdef FT_BRIDGE_STATS_EN
    logic [31:0] tx_words_reg;
    logic [31:0] rx_words_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_words_reg <= '0;
            rx_words_reg <= '0;
        end else begin
            if (tx_beat) tx_words_reg <= tx_words_reg + 32'd1;
            if (rd_req)  rx_words_reg <= rx_words_reg + 32'd1;
        end
    end

    assign tx_words = tx_words_reg;
    assign rx_words = rx_words_reg;
`endif

endmodule
